// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one reg_ctrl register port between NUM_REQ requesters.
// Latency with ready high: write response 2 cycles, read response 3 cycles after request sampled.
// Backpressure: ISSUE holds sel until ready; one transaction outstanding; req_valid ignored outside IDLE.
module reg_bus_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_err,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          sel,
    output logic                          wr,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic [DATA_WIDTH-1:0]         wdata,
    input  logic [DATA_WIDTH-1:0]         rdata,
    input  logic                          ready
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_t;

    // Latched downstream command; drives wr/addr/wdata directly.
    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    state_t                state, state_d;
    logic [PW-1:0]         rr_ptr, rr_ptr_d;
    logic [PW-1:0]         owner, owner_d;
    logic [CW-1:0]         tmo_cnt, tmo_cnt_d;
    cmd_t                  cmd, cmd_d;
    logic [NUM_REQ-1:0]    gnt_d, rsp_valid_d;
    logic                  rsp_err_d, sel_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;

    logic                  found;
    logic [PW-1:0]         win;

    assign wr    = cmd.wr;
    assign addr  = cmd.addr;
    assign wdata = cmd.wdata;

    // Winner: first valid requester searching upward from rr_ptr with wrap.
    always_comb begin
        int            j;
        logic [PW-1:0] cand;
        found = 1'b0;
        win   = '0;
        j     = 0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            cand = PW'(j);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        owner_d     = owner;
        tmo_cnt_d   = tmo_cnt;
        cmd_d       = cmd;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        sel_d       = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_d       = win;
                    cmd_d.wr      = req_wr[win];
                    cmd_d.addr    = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                    cmd_d.wdata   = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
                    gnt_d[win]    = 1'b1;
                    sel_d         = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (ready) begin
                    if (cmd.wr) begin
                        rsp_valid_d[owner] = 1'b1;
                        state_d            = RESP;
                    end else begin
                        tmo_cnt_d = '0;
                        state_d   = RD_WAIT;
                    end
                end else begin
                    sel_d = 1'b1;
                end
            end
            RD_WAIT: begin
                if (ready) begin
                    rsp_valid_d[owner] = 1'b1;
                    rsp_rdata_d        = rdata;
                    state_d            = RESP;
                end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                    // TIMEOUT consecutive not-ready cycles: give up with error.
                    rsp_valid_d[owner] = 1'b1;
                    rsp_err_d          = 1'b1;
                    state_d            = RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt + CW'(1);
                end
            end
            RESP: begin
                rr_ptr_d = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + PW'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            tmo_cnt   <= '0;
            cmd       <= '0;
            req_gnt   <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            sel       <= 1'b0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            owner     <= owner_d;
            tmo_cnt   <= tmo_cnt_d;
            cmd       <= cmd_d;
            req_gnt   <= gnt_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            sel       <= sel_d;
        end
    end

endmodule
